// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: resolution kind
// encodings, index-mode selectors and the saturating-counter operation set.
package bpu_pkg;

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_COND = 2'b01;
   localparam logic [1:0] KIND_JUMP = 2'b10;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

   typedef enum logic [2:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC,
      CNT_MAX,
      CNT_INIT
   } cnt_op_e;

   // Entry layout at the default configuration (32-bit PC, 16 entries,
   // 2-bit counters). The top module declares the same layout sized from
   // its own parameters.
   typedef struct packed {
      logic        valid;
      logic [25:0] tag;
      logic [31:0] target;
      logic [1:0]  cnt;
   } bpu_entry_t;

   // A resolution trains the predictor only for conditionals and jumps;
   // the reserved encoding behaves like "none".
   function automatic logic kind_active(input logic valid, input logic [1:0] kind);
      return valid && (kind == KIND_COND || kind == KIND_JUMP);
   endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Pipeline <-> predictor bus: IF-stage lookup plus MEM-stage resolution.
interface branch_predictor_btb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int HIST_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] if_pc;
   logic                  pred_hit;
   logic                  pred_taken;
   logic [DATA_WIDTH-1:0] pred_target;
   logic [HIST_WIDTH-1:0] pred_hist;

   logic                  upd_valid;
   logic [1:0]            upd_kind;
   logic [DATA_WIDTH-1:0] upd_pc;
   logic                  upd_taken;
   logic [DATA_WIDTH-1:0] upd_target;
   logic                  upd_pred_taken;
   logic [DATA_WIDTH-1:0] upd_pred_target;
   logic [HIST_WIDTH-1:0] upd_hist;

   logic                  mispredict;
   logic                  pred_correct;
   logic [DATA_WIDTH-1:0] redirect_pc;

   // Pipeline side
   modport master (
      output if_pc, upd_valid, upd_kind, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, upd_hist,
      input  pred_hit, pred_taken, pred_target, pred_hist,
             mispredict, pred_correct, redirect_pc
   );

   // Predictor side
   modport slave (
      input  if_pc, upd_valid, upd_kind, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, upd_hist,
      output pred_hit, pred_taken, pred_target, pred_hist,
             mispredict, pred_correct, redirect_pc
   );
endinterface

// File: rtl/sat_counter.sv
// Next-value logic for one saturating counter: increment/decrement clamp at
// the ends, set-max loads all ones, set-init loads the weakly-taken value.
module sat_counter import bpu_pkg::*; #(
   parameter int CNT_WIDTH = 2
) (
   input  cnt_op_e              op,
   input  logic [CNT_WIDTH-1:0] cnt_in,
   output logic [CNT_WIDTH-1:0] cnt_out
);
   localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

   // Apply the requested operation with saturation at both ends
   always_comb begin
      cnt_out = cnt_in;
      case (op)
         CNT_INC:  if (cnt_in != CNT_ONES) cnt_out = cnt_in + CNT_WIDTH'(1);
         CNT_DEC:  if (cnt_in != '0)       cnt_out = cnt_in - CNT_WIDTH'(1);
         CNT_MAX:  cnt_out = CNT_ONES;
         CNT_INIT: cnt_out = CNT_WEAK;
         default:  cnt_out = cnt_in;
      endcase
   end
endmodule

// File: rtl/branch_predictor_btb.sv
// Tagged BTB with per-entry saturating counters, optional gshare indexing,
// same-cycle lookup, MEM-stage training and saturating perf counters.
module branch_predictor_btb import bpu_pkg::*; #(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int CNT_WIDTH  = 2,
   parameter int HIST_WIDTH = 4,
   parameter int MODE       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   branch_predictor_btb_if.slave bus,
   input  logic                  perf_clr,
   output logic [31:0]           branch_cnt,
   output logic [31:0]           mispred_cnt
);
   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX - 2;

   typedef struct packed {
      logic                  valid;
      logic [TAG_W-1:0]      tag;
      logic [DATA_WIDTH-1:0] target;
      logic [CNT_WIDTH-1:0]  cnt;
   } entry_t;

   logic                  valid_q  [ENTRIES];
   logic [CNT_WIDTH-1:0]  cnt_q    [ENTRIES];
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];

   logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
   logic [31:0]           branch_cnt_q, branch_cnt_d;
   logic [31:0]           mispred_cnt_q, mispred_cnt_d;

   logic [IDX-1:0]        lk_idx, up_idx;
   entry_t                lk_ent, up_ent;
   logic                  lk_hit, up_hit;
   logic                  upd_active, upd_is_jump, upd_mis;
   logic                  upd_we, tgt_we;
   cnt_op_e               cnt_op;
   logic [CNT_WIDTH-1:0]  cnt_new;
   logic                  unused_pc_bits;

   // Word-aligned PC bits, optionally folded with history in gshare mode
   function automatic logic [IDX-1:0] make_index(input logic [IDX-1:0] pc_bits,
                                                 input logic [HIST_WIDTH-1:0] hist);
      logic [IDX-1:0] hist_ext;
      hist_ext = '0;
      hist_ext[HIST_WIDTH-1:0] = hist;
      if (MODE != MODE_GSHARE) hist_ext = '0;
      return pc_bits ^ hist_ext;
   endfunction

   assign unused_pc_bits = ^bus.if_pc[1:0];

   // Lookup path: live GHR, old array contents
   assign lk_idx = make_index(bus.if_pc[IDX+1:2], ghr_q);
   assign lk_ent = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx],
                     target: target_q[lk_idx], cnt: cnt_q[lk_idx]};
   assign lk_hit = lk_ent.valid && (lk_ent.tag == bus.if_pc[DATA_WIDTH-1:IDX+2]);

   assign bus.pred_hit    = lk_hit;
   assign bus.pred_taken  = lk_hit && lk_ent.cnt[CNT_WIDTH-1];
   assign bus.pred_target = lk_hit ? lk_ent.target : '0;
   assign bus.pred_hist   = ghr_q;

   // Resolution path: history captured at fetch selects the entry
   assign upd_active  = kind_active(bus.upd_valid, bus.upd_kind);
   assign upd_is_jump = (bus.upd_kind == KIND_JUMP);
   assign up_idx      = make_index(bus.upd_pc[IDX+1:2], bus.upd_hist);
   assign up_ent      = '{valid: valid_q[up_idx], tag: tag_q[up_idx],
                          target: target_q[up_idx], cnt: cnt_q[up_idx]};
   assign up_hit      = up_ent.valid && (up_ent.tag == bus.upd_pc[DATA_WIDTH-1:IDX+2]);

   assign upd_mis = upd_active &&
                    ((bus.upd_pred_taken != bus.upd_taken) ||
                     (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));

   assign bus.mispredict   = upd_mis;
   assign bus.pred_correct = upd_active && bus.upd_taken && !upd_mis;
   assign bus.redirect_pc  = !upd_active    ? '0 :
                             bus.upd_taken  ? bus.upd_target :
                                              bus.upd_pc + DATA_WIDTH'(4);

   // Decide whether the resolving branch writes its entry and how its counter moves
   always_comb begin
      upd_we = 1'b0;
      tgt_we = 1'b0;
      cnt_op = CNT_HOLD;
      if (upd_active) begin
         if (up_hit) begin
            upd_we = 1'b1;
            if (upd_is_jump) begin
               cnt_op = CNT_MAX;
               tgt_we = 1'b1;
            end else begin
               cnt_op = bus.upd_taken ? CNT_INC : CNT_DEC;
               tgt_we = bus.upd_taken;
            end
         end else if (bus.upd_taken) begin
            upd_we = 1'b1;
            tgt_we = 1'b1;
            cnt_op = upd_is_jump ? CNT_MAX : CNT_INIT;
         end
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sat_counter (
      .op      (cnt_op),
      .cnt_in  (up_ent.cnt),
      .cnt_out (cnt_new)
   );

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic                  sel;
         logic                  valid_d;
         logic [CNT_WIDTH-1:0]  cnt_d;
         logic [TAG_W-1:0]      tag_d;
         logic [DATA_WIDTH-1:0] target_d;

         assign sel = upd_we && (up_idx == IDX'(gi));

         // Next contents of this entry (an allocation replaces any occupant)
         always_comb begin
            valid_d  = valid_q[gi];
            cnt_d    = cnt_q[gi];
            tag_d    = tag_q[gi];
            target_d = target_q[gi];
            if (sel) begin
               valid_d = 1'b1;
               cnt_d   = cnt_new;
               tag_d   = bus.upd_pc[DATA_WIDTH-1:IDX+2];
               if (tgt_we) target_d = bus.upd_target;
            end
         end

         // Valid and counter state clears on reset
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_q[gi] <= 1'b0;
               cnt_q[gi]   <= '0;
            end else begin
               valid_q[gi] <= valid_d;
               cnt_q[gi]   <= cnt_d;
            end
         end

         // Tag and target are only meaningful behind valid, so they carry no reset
         always_ff @(posedge clk) begin
            tag_q[gi]    <= tag_d;
            target_q[gi] <= target_d;
         end
      end
   endgenerate

   // Non-speculative history and saturating perf counters; clear beats increment
   always_comb begin
      ghr_d         = ghr_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (upd_active && !upd_is_jump)
         ghr_d = (ghr_q << 1) | HIST_WIDTH'(bus.upd_taken);
      if (perf_clr) begin
         branch_cnt_d  = '0;
         mispred_cnt_d = '0;
      end else begin
         if (upd_active && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + 32'd1;
         if (upd_mis && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   // History and perf counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr_q         <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         ghr_q         <= ghr_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: a vector table on a bimodal instance, then hand-written
// gshare, same-cycle, perf-clear and asynchronous-reset sequences.
module tb_branch_predictor_btb;
   import bpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        perf_clr_b = 1'b0;
   logic        perf_clr_g = 1'b0;
   logic [31:0] branch_cnt_b, mispred_cnt_b, branch_cnt_g, mispred_cnt_g;

   int checks   = 0;
   int failures = 0;

   branch_predictor_btb_if #(.DATA_WIDTH(32), .HIST_WIDTH(4)) bif_b ();
   branch_predictor_btb_if #(.DATA_WIDTH(32), .HIST_WIDTH(4)) bif_g ();

   branch_predictor_btb #(.DATA_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(2),
                          .HIST_WIDTH(4), .MODE(0)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .bus         (bif_b),
      .perf_clr    (perf_clr_b),
      .branch_cnt  (branch_cnt_b),
      .mispred_cnt (mispred_cnt_b)
   );

   branch_predictor_btb #(.DATA_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(2),
                          .HIST_WIDTH(4), .MODE(1)) dut_g (
      .clk         (clk),
      .rst         (rst),
      .bus         (bif_g),
      .perf_clr    (perf_clr_g),
      .branch_cnt  (branch_cnt_g),
      .mispred_cnt (mispred_cnt_g)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [1:0]  kind;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptg;
      logic        exp_mis;
      logic        exp_pc;
      logic [31:0] exp_redir;
      logic [31:0] lk_pc;
      logic        exp_hit;
      logic        exp_tk;
      logic [31:0] exp_tgt;
      logic [31:0] exp_bcnt;
      logic [31:0] exp_mcnt;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic valid, input logic [1:0] kind,
                               input logic [31:0] pc, input logic taken,
                               input logic [31:0] tgt, input logic ptk,
                               input logic [31:0] ptg, input logic emis,
                               input logic epc, input logic [31:0] eredir,
                               input logic [31:0] lk, input logic ehit,
                               input logic etk, input logic [31:0] etgt,
                               input logic [31:0] eb, input logic [31:0] em);
      vec_t v;
      v.valid = valid; v.kind = kind; v.pc = pc; v.taken = taken; v.tgt = tgt;
      v.ptk = ptk; v.ptg = ptg; v.exp_mis = emis; v.exp_pc = epc;
      v.exp_redir = eredir; v.lk_pc = lk; v.exp_hit = ehit; v.exp_tk = etk;
      v.exp_tgt = etgt; v.exp_bcnt = eb; v.exp_mcnt = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_b();
      bif_b.upd_valid = 1'b0; bif_b.upd_kind = KIND_NONE; bif_b.upd_pc = '0;
      bif_b.upd_taken = 1'b0; bif_b.upd_target = '0; bif_b.upd_pred_taken = 1'b0;
      bif_b.upd_pred_target = '0; bif_b.upd_hist = '0;
   endtask

   task automatic idle_g();
      bif_g.upd_valid = 1'b0; bif_g.upd_kind = KIND_NONE; bif_g.upd_pc = '0;
      bif_g.upd_taken = 1'b0; bif_g.upd_target = '0; bif_g.upd_pred_taken = 1'b0;
      bif_g.upd_pred_target = '0; bif_g.upd_hist = '0;
   endtask

   task automatic drive_g(input logic [1:0] kind, input logic [31:0] pc,
                          input logic taken, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptg,
                          input logic [3:0] hist);
      bif_g.upd_valid = 1'b1; bif_g.upd_kind = kind; bif_g.upd_pc = pc;
      bif_g.upd_taken = taken; bif_g.upd_target = tgt;
      bif_g.upd_pred_taken = ptk; bif_g.upd_pred_target = ptg; bif_g.upd_hist = hist;
   endtask

   // One resolution on the bimodal instance, then a lookup after the edge
   task automatic run_vec(input vec_t v, input int n);
      @(negedge clk);
      bif_b.upd_valid = v.valid; bif_b.upd_kind = v.kind; bif_b.upd_pc = v.pc;
      bif_b.upd_taken = v.taken; bif_b.upd_target = v.tgt;
      bif_b.upd_pred_taken = v.ptk; bif_b.upd_pred_target = v.ptg; bif_b.upd_hist = '0;
      #1;
      chk($sformatf("v%0d mispredict", n), 32'(bif_b.mispredict), 32'(v.exp_mis));
      chk($sformatf("v%0d pred_correct", n), 32'(bif_b.pred_correct), 32'(v.exp_pc));
      chk($sformatf("v%0d redirect_pc", n), bif_b.redirect_pc, v.exp_redir);
      @(posedge clk);
      #1;
      idle_b();
      bif_b.if_pc = v.lk_pc;
      #1;
      chk($sformatf("v%0d pred_hit", n), 32'(bif_b.pred_hit), 32'(v.exp_hit));
      chk($sformatf("v%0d pred_taken", n), 32'(bif_b.pred_taken), 32'(v.exp_tk));
      chk($sformatf("v%0d pred_target", n), bif_b.pred_target, v.exp_tgt);
      chk($sformatf("v%0d branch_cnt", n), branch_cnt_b, v.exp_bcnt);
      chk($sformatf("v%0d mispred_cnt", n), mispred_cnt_b, v.exp_mcnt);
      $display("vec %0d: kind=%0d pc=0x%0h taken=%0d -> mis=%0d redir=0x%0h; lookup 0x%0h hit=%0d taken=%0d tgt=0x%0h",
               n, v.kind, v.pc, v.taken, bif_b.mispredict, v.exp_redir, v.lk_pc,
               bif_b.pred_hit, bif_b.pred_taken, bif_b.pred_target);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //             vld kind       pc            t  tgt           ptk ptg        mis pc redir          lookup        hit tk tgt          b  m
      vecs[0]  = mk(1, KIND_COND, 32'h100,      1, 32'h80,  0, 32'h0,   1, 0, 32'h80,  32'h100, 1, 1, 32'h80,  1, 1);
      vecs[1]  = mk(1, KIND_COND, 32'h100,      0, 32'h0,   1, 32'h80,  1, 0, 32'h104, 32'h100, 1, 0, 32'h80,  2, 2);
      vecs[2]  = mk(1, KIND_COND, 32'h100,      0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 32'h100, 1, 0, 32'h80,  3, 2);
      vecs[3]  = mk(1, KIND_COND, 32'h100,      0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 32'h100, 1, 0, 32'h80,  4, 2);
      vecs[4]  = mk(1, KIND_COND, 32'h100,      1, 32'h80,  0, 32'h0,   1, 0, 32'h80,  32'h100, 1, 0, 32'h80,  5, 3);
      vecs[5]  = mk(1, KIND_JUMP, 32'h200,      1, 32'h400, 0, 32'h0,   1, 0, 32'h400, 32'h200, 1, 1, 32'h400, 6, 4);
      vecs[6]  = mk(1, KIND_JUMP, 32'h200,      1, 32'h400, 1, 32'h400, 0, 1, 32'h400, 32'h200, 1, 1, 32'h400, 7, 4);
      vecs[7]  = mk(1, KIND_JUMP, 32'h200,      1, 32'h400, 1, 32'h400, 0, 1, 32'h400, 32'h200, 1, 1, 32'h400, 8, 4);
      vecs[8]  = mk(1, KIND_JUMP, 32'h200,      1, 32'h400, 1, 32'h400, 0, 1, 32'h400, 32'h200, 1, 1, 32'h400, 9, 4);
      vecs[9]  = mk(1, KIND_JUMP, 32'h200,      1, 32'h400, 1, 32'h400, 0, 1, 32'h400, 32'h200, 1, 1, 32'h400, 10, 4);
      vecs[10] = mk(0, KIND_COND, 32'h100,      1, 32'h80,  0, 32'h0,   0, 0, 32'h0,   32'h100, 0, 0, 32'h0,   10, 4);
      vecs[11] = mk(1, KIND_COND, 32'h100,      1, 32'h80,  0, 32'h0,   1, 0, 32'h80,  32'h140, 0, 0, 32'h0,   11, 5);
      vecs[12] = mk(1, KIND_COND, 32'h140,      1, 32'h300, 0, 32'h0,   1, 0, 32'h300, 32'h140, 1, 1, 32'h300, 12, 6);
      vecs[13] = mk(1, KIND_NONE, 32'h140,      1, 32'h500, 0, 32'h0,   0, 0, 32'h0,   32'h100, 0, 0, 32'h0,   12, 6);
      vecs[14] = mk(1, 2'b11,     32'h140,      1, 32'h500, 0, 32'h0,   0, 0, 32'h0,   32'h140, 1, 1, 32'h300, 12, 6);
      vecs[15] = mk(1, KIND_COND, 32'h140,      1, 32'h300, 1, 32'h300, 0, 1, 32'h300, 32'h140, 1, 1, 32'h300, 13, 6);
      vecs[16] = mk(1, KIND_COND, 32'h140,      1, 32'h340, 1, 32'h300, 1, 0, 32'h340, 32'h140, 1, 1, 32'h340, 14, 7);
      vecs[17] = mk(1, KIND_COND, 32'h104,      0, 32'h0,   0, 32'h0,   0, 0, 32'h108, 32'h104, 0, 0, 32'h0,   15, 7);
      vecs[18] = mk(1, KIND_COND, 32'hFFFFFFFC, 0, 32'h0,   1, 32'h10,  1, 0, 32'h0,   32'hFFFFFFFC, 0, 0, 32'h0, 16, 8);

      idle_b();
      idle_g();
      bif_b.if_pc = 32'h100;
      bif_g.if_pc = 32'h100;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset pred_hit", 32'(bif_b.pred_hit), 32'd0);
      chk("reset pred_taken", 32'(bif_b.pred_taken), 32'd0);
      chk("reset pred_target", bif_b.pred_target, 32'h0);
      chk("reset pred_hist", 32'(bif_g.pred_hist), 32'h0);
      chk("reset branch_cnt", branch_cnt_b, 32'd0);
      chk("reset mispred_cnt", mispred_cnt_b, 32'd0);
      $display("reset: lookup 0x100 hit=%0d taken=%0d tgt=0x%0h counters=%0d/%0d",
               bif_b.pred_hit, bif_b.pred_taken, bif_b.pred_target, branch_cnt_b, mispred_cnt_b);

      // Table-driven bimodal vectors
      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Gshare: three taken conditionals build history 0b0111
      for (int i = 0; i < 3; i++) begin
         logic [3:0] h;
         logic [3:0] exp_h;
         h = (i == 0) ? 4'h0 : (i == 1) ? 4'h1 : 4'h3;
         exp_h = (i == 0) ? 4'h1 : (i == 1) ? 4'h3 : 4'h7;
         @(negedge clk);
         drive_g(KIND_COND, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, h);
         @(posedge clk);
         #1;
         idle_g();
         #1;
         chk($sformatf("gshare hist step %0d", i), 32'(bif_g.pred_hist), 32'(exp_h));
         $display("gshare resolve %0d: pc=0x100 taken hist_in=0x%0h -> pred_hist=0x%0h", i, h, bif_g.pred_hist);
      end
      chk("gshare branch_cnt", branch_cnt_g, 32'd3);
      chk("gshare mispred_cnt", mispred_cnt_g, 32'd3);

      // Lookup 0x100 folds to index 7 (empty); 0x11C folds to index 0
      bif_g.if_pc = 32'h100;
      #1;
      chk("gshare lookup 0x100 hit", 32'(bif_g.pred_hit), 32'd0);
      bif_g.if_pc = 32'h11C;
      #1;
      chk("gshare lookup 0x11C hit", 32'(bif_g.pred_hit), 32'd1);
      chk("gshare lookup 0x11C target", bif_g.pred_target, 32'h80);
      $display("gshare lookup: 0x11C hit=%0d tgt=0x%0h", bif_g.pred_hit, bif_g.pred_target);

      // Same-cycle lookup and update of index 0, with perf_clr alongside a mispredict
      @(negedge clk);
      drive_g(KIND_COND, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 4'h0);
      perf_clr_g = 1'b1;
      #1;
      chk("same-cycle old target", bif_g.pred_target, 32'h80);
      chk("same-cycle old taken", 32'(bif_g.pred_taken), 32'd1);
      chk("same-cycle mispredict", 32'(bif_g.mispredict), 32'd1);
      chk("same-cycle redirect_pc", bif_g.redirect_pc, 32'h90);
      @(posedge clk);
      #1;
      idle_g();
      perf_clr_g = 1'b0;
      bif_g.if_pc = 32'h13C;
      #1;
      chk("clr branch_cnt", branch_cnt_g, 32'd0);
      chk("clr mispred_cnt", mispred_cnt_g, 32'd0);
      chk("after update pred_hist", 32'(bif_g.pred_hist), 32'hF);
      chk("after update hit", 32'(bif_g.pred_hit), 32'd1);
      chk("after update taken", 32'(bif_g.pred_taken), 32'd1);
      chk("after update target", bif_g.pred_target, 32'h90);
      $display("same-cycle: old tgt seen, then lookup 0x13C tgt=0x%0h counters=%0d/%0d",
               bif_g.pred_target, branch_cnt_g, mispred_cnt_g);

      // Not-taken miss: counted, no write, no mispredict
      @(negedge clk);
      drive_g(KIND_COND, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 4'hF);
      @(posedge clk);
      #1;
      idle_g();
      #1;
      chk("post-clr branch_cnt", branch_cnt_g, 32'd1);
      chk("post-clr mispred_cnt", mispred_cnt_g, 32'd0);
      $display("not-taken miss at 0x200: branch_cnt=%0d", branch_cnt_g);

      // Asynchronous reset mid-cycle while an update is presented
      #2;
      drive_g(KIND_COND, 32'h100, 1'b1, 32'h44, 1'b0, 32'h0, 4'h0);
      rst = 1'b0;
      #1;
      chk("async rst pred_hit", 32'(bif_g.pred_hit), 32'd0);
      chk("async rst pred_target", bif_g.pred_target, 32'h0);
      chk("async rst pred_hist", 32'(bif_g.pred_hist), 32'h0);
      chk("async rst branch_cnt", branch_cnt_g, 32'd0);
      chk("async rst mispredict", 32'(bif_g.mispredict), 32'd1);
      chk("async rst redirect_pc", bif_g.redirect_pc, 32'h44);
      @(posedge clk);
      #1;
      chk("held rst branch_cnt", branch_cnt_g, 32'd0);
      chk("held rst pred_hit", 32'(bif_g.pred_hit), 32'd0);
      $display("async reset: hit=%0d hist=0x%0h cnt=%0d mispredict=%0d",
               bif_g.pred_hit, bif_g.pred_hist, branch_cnt_g, bif_g.mispredict);
      @(negedge clk);
      idle_g();
      rst = 1'b1;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch prediction unit: a tagged branch target buffer with per-entry saturating counters and an optional global-history (gshare) index. Sits beside the 5-stage pipeline; answers an IF-stage lookup in the same cycle and trains from the MEM-stage branch resolution. Drives the pipeline's IF redirect (`pred_taken` / `pred_target`) and its MEM mispredict recovery (`mispredict` / `pred_correct` / `redirect_pc`). Also keeps saturating performance counters.

## Interface
- `DATA_WIDTH`, 32, PC and target width.
- `ENTRIES`, 16, BTB depth; power of two, at least 2. `IDX = log2(ENTRIES)`.
- `CNT_WIDTH`, 2, saturating counter width; at least 1.
- `HIST_WIDTH`, 4, global history width; at most `IDX`.
- `MODE`, 0, index mode: 0 = bimodal, 1 = gshare.
- `clk` in 1, the single clock.
- `rst` in 1, reset; asynchronous and active-low.
- `if_pc` in DATA_WIDTH, IF-stage PC.
- `pred_hit` out 1, lookup matched a valid entry.
- `pred_taken` out 1, predict taken.
- `pred_target` out DATA_WIDTH, predicted target.
- `pred_hist` out HIST_WIDTH, GHR at lookup; carried down the pipe by the datapath.
- `upd_valid` in 1, MEM-stage resolution valid.
- `upd_kind` in 2, 00 none, 01 conditional, 10 jump (jal/jalr), 11 reserved (treated as none).
- `upd_pc` in DATA_WIDTH, PC of the resolving branch.
- `upd_taken` in 1, actual outcome.
- `upd_target` in DATA_WIDTH, actual target.
- `upd_pred_taken` in 1, prediction that branch was fetched with.
- `upd_pred_target` in DATA_WIDTH, target that branch was fetched with.
- `upd_hist` in HIST_WIDTH, `pred_hist` captured at fetch.
- `mispredict` out 1, redirect required.
- `pred_correct` out 1, taken branch was predicted correctly.
- `redirect_pc` out DATA_WIDTH, recovery PC.
- `perf_clr` in 1, synchronous clear of the perf counters.
- `branch_cnt` out 32, resolved branches and jumps.
- `mispred_cnt` out 32, mispredictions.

## Operation
- **Entry fields:** `valid`, `tag = pc[DATA_WIDTH-1:IDX+2]`, `target`, `cnt[CNT_WIDTH]`.
- **Index:**
  - Bimodal: `pc[IDX+1:2]`.
  - Gshare: `pc[IDX+1:2] ^ zero-extended history`.
  - Lookup uses the live GHR; update uses `upd_hist`.
- **Lookup (combinational):**
  - `pred_hit = valid & tag match`.
  - `pred_taken = pred_hit & cnt[MSB]`.
  - `pred_target` = entry target on a hit, else 0.
- **Resolution, active when `upd_valid` and kind is 01/10:**
  - `mispredict = (upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)`.
  - `pred_correct = upd_taken & ~mispredict`.
  - `redirect_pc = upd_taken ? upd_target : upd_pc + 4`, computed modulo 2^DATA_WIDTH.
  - When not active, all three outputs are 0.
- **Training (clock edge):**
  - Hit, conditional: `cnt` saturating +1 if taken, -1 if not; target overwritten when taken.
  - Hit, jump: `cnt` set to all-ones; target overwritten.
  - Miss and taken: allocate (replacing any occupant). Tag and target written; `cnt` = 2^(CNT_WIDTH-1) (weakly taken); jumps get all-ones.
  - Miss and not taken: no write.
- **GHR:** shifts left, inserting `upd_taken`, only on an active conditional resolution. The GHR is non-speculative.
- **Perf counters:**
  - `branch_cnt` +1 per active resolution.
  - `mispred_cnt` +1 per `mispredict`.
  - Both saturate at all-ones.
  - `perf_clr` wins over an increment in the same cycle.

## Timing
- Lookup outputs and resolution outputs are purely combinational; zero latency.
- Training writes take effect at the next rising edge. A same-cycle lookup of the entry being updated returns the old contents.
- **Reset (async assert, any time, including mid-update):**
  - All `valid` = 0, `cnt` = 0, GHR = 0, both perf counters = 0.
  - Outputs during and after reset: `pred_hit` / `pred_taken` = 0, `pred_target` = 0, `pred_hist` = 0.
  - `mispredict` / `pred_correct` / `redirect_pc` follow the inputs only.
- Release of reset is synchronised by the integrator. The first training write may occur on the first edge after release.

## Structure
- Shared package `bpu_pkg`:
  - `upd_kind` encodings (`KIND_NONE`, `KIND_COND`, `KIND_JUMP`).
  - `MODE_BIMODAL` / `MODE_GSHARE` constants.
  - Entry struct type.
- One sub-module: `sat_counter` (parametrised by `CNT_WIDTH`). Provides inc/dec/set-max/set-init with saturation; one instance per entry or a shared next-value function.

## Test plan
- Reset, then `if_pc` = 0x100 → `pred_hit` = 0, `pred_taken` = 0, `pred_target` = 0, both counters 0.
- Resolve cond at 0x100, taken, target 0x80, pred_taken 0 → `mispredict` = 1, `redirect_pc` = 0x80, `mispred_cnt` = 1. Next cycle lookup 0x100 → hit, taken, target 0x80.
- Three not-taken resolutions of 0x100 → `cnt` goes 2→1→0→0. The first gives `mispredict` = 1 with `redirect_pc` = 0x104; lookup then predicts not taken.
- Jump at 0x200 to 0x400, resolved 5 times → `cnt` stays 3, always taken; `pred_correct` = 1 once prediction matches.
- `ENTRIES` = 16: allocate 0x100, then lookup 0x140 → miss (same index, different tag). Taken resolve at 0x140 replaces it; 0x100 then misses.
- `MODE` = 1: three taken conditionals → `pred_hist` = 0b0111. Lookup and update the same PC in the same cycle → old data returned. `perf_clr` together with a mispredict → counters read 0.
